// File: rtl/rtc_stopwatch_core.sv
// Single-button stopwatch: conditioned trigger drives an IDLE/RUN/HOLD controller,
// a 6-digit BCD hundredths counter and a multiplexed seven-segment display.
module rtc_stopwatch_core #(
  parameter int TICK_DIV        = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_DIV     = 100_000
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       trigger_in,
  output logic [7:0] segments,
  output logic [7:0] digits
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REF_W  = $clog2(REFRESH_DIV + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  logic              trig_p0, trig_p1;
  logic              deb_level, deb_prev, press;
  logic [DEB_W-1:0]  deb_cnt;
  state_t            state, state_next;
  logic              count_init, count_enb, latch_count;
  logic [TICK_W-1:0] tick_cnt;
  logic              base_tick;
  logic [23:0]       count, latched, shown;
  logic [REF_W-1:0]  refresh_cnt;
  logic [2:0]        scan_idx;
  logic [3:0]        nibble;

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Stage: 2-FF synchronizer
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_p0 <= 1'b0;
      trig_p1 <= 1'b0;
    end else begin
      trig_p0 <= trigger_in;
      trig_p1 <= trig_p0;
    end
  end

  // Stage: debouncer, level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      deb_prev <= deb_level;
      if (trig_p1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= trig_p1;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press = deb_level & ~deb_prev;

  // Stage: control FSM
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    count_init  = 1'b0;
    count_enb   = 1'b0;
    latch_count = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (press) begin
          count_init = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // A press masks count_enb so a coincident tick is never applied.
        if (press) begin
          latch_count = 1'b1;
          state_next  = HOLD;
        end else begin
          count_enb = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage: base-tick timer and BCD counter
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      count    <= '0;
      latched  <= '0;
    end else begin
      if (count_init)     tick_cnt <= '0;
      else if (count_enb) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      if (count_init)                  count <= '0;
      else if (base_tick && count_enb) count <= bcd_inc(count);
      if (latch_count) latched <= count;
    end
  end

  assign base_tick = count_enb && (tick_cnt == TICK_LAST);

  always_comb begin
    shown = '0;
    if (state == RUN)       shown = count;
    else if (state == HOLD) shown = latched;
    nibble = shown[{scan_idx, 2'b00} +: 4];
  end

  // Stage: scan adapter with registered outputs
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      scan_idx    <= 3'd0;
      segments    <= 8'hFF;
      digits      <= 8'hFF;
    end else begin
      if (refresh_cnt == REF_LAST) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      digits   <= ~(8'd1 << scan_idx);
      segments <= {scan_idx != 3'd2, seg_decode(nibble)};
    end
  end

endmodule

// File: tb/tb_rtc_stopwatch_core.sv
// Bench for rtc_stopwatch_core: scenario tasks with randomized timing, expected
// counts derived from elapsed RUN cycles divided by the tick period.
module tb_rtc_stopwatch_core;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int REF      = 2;

  logic       sys_clk    = 1'b0;
  logic       reset_n    = 1'b0;
  logic       trigger_in = 1'b0;
  logic [7:0] segments, digits;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int run_start = 0;

  logic [7:0] disp_seg [6];
  bit         disp_seen [6];
  int         disp_bad;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  rtc_stopwatch_core #(
    .TICK_DIV(TICK_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .REFRESH_DIV(REF)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .trigger_in(trigger_in),
    .segments(segments),
    .digits(digits)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int          x;
    x = v % 1000000;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Ticks seen after the edge numbered n in a run that began at run_start.
  function automatic int exp_count(input int n);
    return (n - run_start) / TICK_DIV;
  endfunction

  // Presses take effect as RUN/HOLD entry six edges after the rise is driven.
  task automatic press(output int c);
    c = cyc;
    trigger_in = 1'b1;
    repeat (4) @(negedge sys_clk);
    trigger_in = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic glitch(input int len);
    trigger_in = 1'b1;
    repeat (len) @(negedge sys_clk);
    trigger_in = 1'b0;
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  task automatic read_display();
    int lows, idx;
    disp_bad = 0;
    for (int i = 0; i < 6; i++) begin
      disp_seen[i] = 1'b0;
      disp_seg[i]  = 8'hFF;
    end
    repeat (14) begin
      @(negedge sys_clk);
      lows = 0;
      idx  = 0;
      for (int j = 0; j < 8; j++) begin
        if (digits[j] === 1'b0) begin
          lows++;
          idx = j;
        end
      end
      if (lows != 1 || idx > 5) disp_bad++;
      else begin
        disp_seen[idx] = 1'b1;
        disp_seg[idx]  = segments;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (digits !== 8'hFF) begin
      n_fail++; $display("FAIL reset_digits: got %h expected ff", digits);
    end
    n_checks++;
    if (segments !== 8'hFF) begin
      n_fail++; $display("FAIL reset_segments: got %h expected ff", segments);
    end
    reset_n = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (digits !== 8'hFE) begin
      n_fail++; $display("FAIL release_digits: got %h expected fe", digits);
    end
    n_checks++;
    if (segments !== 8'hC0) begin
      n_fail++; $display("FAIL release_segments: got %h expected c0", segments);
    end
    n_checks++;
    if (dut.count !== 24'h0) begin
      n_fail++; $display("FAIL release_count: got %h expected 000000", dut.count);
    end
  endtask

  task automatic test_scan();
    int         idx;
    logic [7:0] ed, es;
    for (int k = 1; k < 14; k++) begin
      @(negedge sys_clk);
      idx = (k / 2) % 6;
      ed  = ~(8'd1 << idx);
      es  = (idx == 2) ? 8'h40 : 8'hC0;
      n_checks++;
      if (digits !== ed) begin
        n_fail++; $display("FAIL scan_digits k=%0d: got %h expected %h", k, digits, ed);
      end
      n_checks++;
      if (segments !== es) begin
        n_fail++; $display("FAIL scan_segments k=%0d: got %h expected %h", k, segments, es);
      end
    end
  endtask

  task automatic test_glitch_idle();
    logic [7:0] e;
    glitch($urandom_range(1, 2));
    n_checks++;
    if (dut.count !== 24'h0) begin
      n_fail++; $display("FAIL glitch_idle_count: got %h expected 000000", dut.count);
    end
    read_display();
    n_checks++;
    if (disp_bad !== 0) begin
      n_fail++; $display("FAIL glitch_idle_scan: got %0d bad samples expected 0", disp_bad);
    end
    for (int i = 0; i < 6; i++) begin
      e = (i == 2) ? 8'h40 : 8'hC0;
      n_checks++;
      if (!disp_seen[i] || disp_seg[i] !== e) begin
        n_fail++; $display("FAIL glitch_idle_digit%0d: got %h expected %h", i, disp_seg[i], e);
      end
    end
  endtask

  task automatic test_start();
    int c;
    press(c);
    run_start = c + 6;
    wait_cyc(run_start + 40);
    n_checks++;
    if (dut.count !== 24'h000010) begin
      n_fail++; $display("FAIL start_40cyc: got %h expected 000010", dut.count);
    end
    repeat (3) begin
      repeat ($urandom_range(1, 9)) @(negedge sys_clk);
      n_checks++;
      if (dut.count !== to_bcd(exp_count(cyc))) begin
        n_fail++; $display("FAIL start_live: got %h expected %h", dut.count, to_bcd(exp_count(cyc)));
      end
    end
  endtask

  task automatic test_stop(input bit align_tick);
    int          c, held, guard;
    logic [23:0] hb;
    logic [7:0]  e;
    if (align_tick) begin
      guard = 0;
      while (((cyc + 6 - run_start) % TICK_DIV) != 0 && guard < 8) begin
        @(negedge sys_clk);
        guard++;
      end
    end else begin
      repeat ($urandom_range(0, 7)) @(negedge sys_clk);
    end
    press(c);
    // The HOLD-entry edge is c+6; any tick due on that edge is dropped.
    held = (c + 5 - run_start) / TICK_DIV;
    if (align_tick) held = (c + 6 - run_start) / TICK_DIV - 1;
    hb = to_bcd(held);
    n_checks++;
    if (dut.count !== hb) begin
      n_fail++; $display("FAIL stop_latched a=%0d: got %h expected %h", align_tick, dut.count, hb);
    end
    repeat ($urandom_range(5, 20)) @(negedge sys_clk);
    n_checks++;
    if (dut.count !== hb) begin
      n_fail++; $display("FAIL stop_frozen: got %h expected %h", dut.count, hb);
    end
    read_display();
    n_checks++;
    if (disp_bad !== 0) begin
      n_fail++; $display("FAIL hold_scan: got %0d bad samples expected 0", disp_bad);
    end
    for (int i = 0; i < 6; i++) begin
      e = seg_tab[hb[4*i +: 4]];
      if (i == 2) e = e & 8'h7F;
      n_checks++;
      if (!disp_seen[i] || disp_seg[i] !== e) begin
        n_fail++; $display("FAIL hold_digit%0d: got %h expected %h", i, disp_seg[i], e);
      end
    end
  endtask

  task automatic test_restart();
    int c;
    press(c);
    run_start = c + 6;
    n_checks++;
    if (dut.count !== to_bcd(exp_count(cyc))) begin
      n_fail++; $display("FAIL restart_early: got %h expected %h", dut.count, to_bcd(exp_count(cyc)));
    end
    repeat ($urandom_range(10, 40)) @(negedge sys_clk);
    n_checks++;
    if (dut.count !== to_bcd(exp_count(cyc))) begin
      n_fail++; $display("FAIL restart_live: got %h expected %h", dut.count, to_bcd(exp_count(cyc)));
    end
  endtask

  task automatic test_wrap();
    int w0, guard;
    guard = 0;
    while (!(cyc > run_start && ((cyc - run_start) % TICK_DIV) == 0) && guard < 8) begin
      @(negedge sys_clk);
      guard++;
    end
    w0 = cyc;
    force dut.count = 24'h999999;
    @(negedge sys_clk);
    release dut.count;
    wait_cyc(w0 + 3);
    n_checks++;
    if (dut.count !== 24'h999999) begin
      n_fail++; $display("FAIL wrap_preload: got %h expected 999999", dut.count);
    end
    @(negedge sys_clk);
    n_checks++;
    if (dut.count !== 24'h000000) begin
      n_fail++; $display("FAIL wrap_roll: got %h expected 000000", dut.count);
    end
    run_start = w0 + 4;
    wait_cyc(w0 + 8);
    n_checks++;
    if (dut.count !== 24'h000001) begin
      n_fail++; $display("FAIL wrap_next: got %h expected 000001", dut.count);
    end
  endtask

  task automatic test_glitch_run();
    int c;
    press(c);
    run_start = c + 6;
    repeat (3) begin
      glitch($urandom_range(1, 2));
      n_checks++;
      if (dut.count !== to_bcd(exp_count(cyc))) begin
        n_fail++; $display("FAIL glitch_run: got %h expected %h", dut.count, to_bcd(exp_count(cyc)));
      end
    end
  endtask

  task automatic test_reset_midrun();
    int         c;
    logic [7:0] e;
    repeat ($urandom_range(1, 6)) @(negedge sys_clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (digits !== 8'hFF || segments !== 8'hFF) begin
      n_fail++; $display("FAIL midrun_reset_out: got %h/%h expected ff/ff", digits, segments);
    end
    n_checks++;
    if (dut.count !== 24'h0) begin
      n_fail++; $display("FAIL midrun_reset_count: got %h expected 000000", dut.count);
    end
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (digits !== 8'hFE || segments !== 8'hC0) begin
      n_fail++; $display("FAIL midrun_release_out: got %h/%h expected fe/c0", digits, segments);
    end
    read_display();
    for (int i = 0; i < 6; i++) begin
      e = (i == 2) ? 8'h40 : 8'hC0;
      n_checks++;
      if (!disp_seen[i] || disp_seg[i] !== e) begin
        n_fail++; $display("FAIL midrun_idle_digit%0d: got %h expected %h", i, disp_seg[i], e);
      end
    end
    press(c);
    run_start = c + 6;
    repeat ($urandom_range(4, 30)) @(negedge sys_clk);
    n_checks++;
    if (dut.count !== to_bcd(exp_count(cyc))) begin
      n_fail++; $display("FAIL midrun_restart: got %h expected %h", dut.count, to_bcd(exp_count(cyc)));
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch_idle();
    test_start();
    test_stop(1'b0);
    test_restart();
    test_wrap();
    test_stop(1'b1);
    test_glitch_run();
    test_stop(1'b0);
    test_restart();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_stopwatch_core.md
Name: rtc_stopwatch_core

Overview:
- Top-level single-button stopwatch for the Nexys A7-100.
- A conditioned trigger input starts, stops and restarts a 6-digit BCD time count advanced by a prescaled base tick.
- The count drives 8-digit multiplexed seven-segment outputs; only the lower 6 digits are used.
- Internally it is composed of five stages: trigger detection, base-tick timer, 24-bit BCD counter, display decoder and scan adapter.

Parameters:
- TICK_DIV, 1_000_000: sys_clk cycles per base tick (10 ms at 100 MHz, so the count is in hundredths of a second).
- DEBOUNCE_CYCLES, 1_000_000: number of cycles the synchronized trigger must be stable before it is accepted.
- REFRESH_DIV, 100_000: sys_clk cycles each digit stays lit during multiplexing.

Ports:
- sys_clk, input, 1: system clock (100 MHz).
- reset_n, input, 1: asynchronous active-low reset. It clears all state; all logic is clocked by the single clock sys_clk.
- trigger_in, input, 1: pushbutton, active-high, asynchronous to sys_clk.
- segments, output, 8: cathodes, active-low, {dp,g,f,e,d,c,b,a}.
- digits, output, 8: anodes, active-low, bit0 = rightmost digit.

Behaviour:
- Trigger conditioning:
  - trigger_in passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a one-cycle pulse on the debounced rising edge. Release does nothing.
- Control FSM (states IDLE, RUN, HOLD; reset state IDLE):
  - IDLE + press: assert count_init for 1 cycle, go to RUN.
  - RUN: count_enb = 1. A press drops count_enb, pulses latch_count for 1 cycle, and goes to HOLD.
  - HOLD + press: count_init pulse, go to RUN (count restarts from 0).
  - count_init, count_enb and latch_count are internal. They are 0 in reset and in IDLE/HOLD except for the pulses above.
- Timer:
  - Free-running modulo-TICK_DIV counter that is cleared by count_init.
  - base_tick is a 1-cycle pulse when the counter reaches TICK_DIV-1. It runs only while count_enb = 1.
- Counter:
  - 24-bit value made of 6 BCD nibbles [23:20]..[3:0].
  - count_init sets it to 0; count_init has priority over tick.
  - On base_tick with count_enb = 1, it increments with decimal carry.
  - 999999 wraps to 000000.
  - Nibbles never exceed 9. Reset value is 0.
- Display value:
  - RUN shows the live count.
  - HOLD shows the value captured on latch_count, which equals the final count.
  - IDLE shows 000000.
- Decoder: each nibble maps to standard active-low seven-segment codes: 0 = C0h, 1 = F9h, 2 = A4h, 3 = B0h, 4 = 99h, 5 = 92h, 6 = 82h, 7 = F8h, 8 = 80h, 9 = 90h.
- Decimal point (dp = 0) is lit on digit 2 only, so the display reads SSSS.hh.
- Scan adapter:
  - A scan index 0..5 advances every REFRESH_DIV cycles and wraps 5 to 0.
  - digits has exactly one of bits [5:0] low. Bits [7:6] are always 1.
  - segments carries the code for the selected digit.
- Reset (asynchronous):
  - segments = FFh and digits = FFh while reset_n = 0.
  - In the first cycle after release, scan index is 0, so digits = FEh and segments = C0h.
  - Reset mid-run returns to IDLE with count 0.
- Simultaneous events: a press in the same cycle as base_tick while in RUN stops the counter before that tick is applied. The latched value excludes that tick.

Test Plan:
- Use TICK_DIV = 4, DEBOUNCE_CYCLES = 3, REFRESH_DIV = 2 for all scenarios.
- Reset: hold reset_n = 0 → digits = FFh, segments = FFh. After release → digits = FEh, segments = C0h, and the display reads 000000.
- Start: press and release → count_init pulses once, then count increments by 1 every 4 cycles. After 40 cycles of RUN, count = 000010 (BCD).
- Stop/hold: second press → count_enb = 0, latch_count pulses, count frozen at the latched value. digit0/1/2 segments show the latched digits, with dp low only on digit 2.
- Restart: third press → count resets to 000000 and resumes counting.
- Wrap: force/preload count 999999 in RUN, one tick → 000000.
- Glitch rejection: a 1-cycle trigger_in pulse → no state change. Scan check: digits cycles FEh, FDh, FBh, F7h, EFh, DFh, FEh, one step every 2 cycles.
